// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, WIDTH data bits LSB-first, stop bit,
// each bit held for DIV clocks. Handshake: a word is accepted on a rising edge where load=1 and ready=1.
module serial_frame_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             busy,
  output logic             txd,
  output logic             done,
  output logic [1:0]       fsm_state
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nx;
  logic [DW-1:0]    div_cnt, div_nx;
  logic [BW-1:0]    bit_cnt, bit_nx;
  logic [WIDTH-1:0] shift, shift_nx, shift_sh;
  logic             txd_nx, ready_nx, busy_nx, done_nx;
  logic             tc;

  assign fsm_state = state;
  assign tc        = (div_cnt == DW'(DIV - 1));
  assign shift_sh  = shift >> 1;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      txd     <= 1'b1;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      div_cnt <= div_nx;
      bit_cnt <= bit_nx;
      shift   <= shift_nx;
      txd     <= txd_nx;
      ready   <= ready_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    div_nx   = tc ? '0 : div_cnt + DW'(1);
    bit_nx   = bit_cnt;
    shift_nx = shift;
    txd_nx   = txd;
    ready_nx = ready;
    busy_nx  = busy;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        div_nx = '0;
        if (load) begin
          shift_nx = data;
          state_nx = START;
          txd_nx   = 1'b0;
          ready_nx = 1'b0;
          busy_nx  = 1'b1;
        end
      end
      START: begin
        if (tc) begin
          state_nx = DATA;
          bit_nx   = '0;
          txd_nx   = shift[0];
        end
      end
      DATA: begin
        if (tc) begin
          shift_nx = shift_sh;
          if (bit_cnt == BW'(WIDTH - 1)) begin
            state_nx = STOP;
            txd_nx   = 1'b1;
          end else begin
            // the next bit is the LSB of the shifted word
            bit_nx = bit_cnt + BW'(1);
            txd_nx = shift_sh[0];
          end
        end
      end
      STOP: begin
        if (tc) begin
          state_nx = IDLE;
          txd_nx   = 1'b1;
          ready_nx = 1'b1;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: directed frame table, randomized frames against a frame-level
// model, asynchronous reset mid-frame, and a DIV=1/WIDTH=1 instance.
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       clr;
  logic       load;
  logic [7:0] data;
  logic       ready, busy, txd, done;
  logic [1:0] fsm_state;

  logic       load1;
  logic [0:0] data1;
  logic       ready1, busy1, txd1, done1;
  logic [1:0] fsm_state1;

  int checks = 0;
  int failures = 0;

  localparam int FLEN = 40;

  serial_frame_tx #(.WIDTH(8), .DIV(4)) dut (
    .clk(clk), .clr(clr), .load(load), .data(data),
    .ready(ready), .busy(busy), .txd(txd), .done(done), .fsm_state(fsm_state)
  );

  serial_frame_tx #(.WIDTH(1), .DIV(1)) dut1 (
    .clk(clk), .clr(clr), .load(load1), .data(data1),
    .ready(ready1), .busy(busy1), .txd(txd1), .done(done1), .fsm_state(fsm_state1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // frame[i] is the i-th bit on the line in time order (start, d0..d7, stop)
  task automatic run_frame(input logic [9:0] frame, input int pulse_at, input bit keep,
                           input logic [7:0] next_d);
    for (int n = 0; n <= FLEN; n++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("txd n=%0d", n), txd, (n < FLEN) ? frame[n / 4] : 1'b1);
      chk($sformatf("busy n=%0d", n), busy, n < FLEN);
      chk($sformatf("ready n=%0d", n), ready, n == FLEN);
      chk($sformatf("done n=%0d", n), done, n == FLEN);
      if (n == 0) begin
        if (keep) data = next_d;
        else begin
          load = 1'b0;
          data = 8'($urandom_range(0, 255));
        end
      end
      if (n == pulse_at) begin
        load = 1'b1;
        data = 8'h3C;
      end
      if (n == pulse_at + 1) load = 1'b0;
    end
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " idle done"}, done, 1'b0);
    chk({tag, " idle busy"}, busy, 1'b0);
    chk({tag, " idle ready"}, ready, 1'b1);
    chk({tag, " idle txd"}, txd, 1'b1);
  endtask

  typedef struct {
    logic [7:0] d;
    logic [9:0] frame;
    int         pulse_at;
    bit         keep;
    logic [7:0] next_d;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bit prev_keep;
    logic [7:0] rd;
    int pa;
    logic [3:0] exp_txd1;

    vecs[0] = '{8'hA5, 10'h34A, 10, 1'b0, 8'h00};
    vecs[1] = '{8'hFF, 10'h3FE, -5, 1'b1, 8'h00};
    vecs[2] = '{8'h00, 10'h200, -5, 1'b0, 8'h00};
    vecs[3] = '{8'h3C, 10'h278, 3, 1'b0, 8'h00};

    clr = 1'b1; load = 1'b0; data = '0; load1 = 1'b0; data1 = '0;
    #1;
    chk("reset txd", txd, 1'b1);
    chk("reset ready", ready, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    idle_check("post-reset");

    prev_keep = 1'b0;
    foreach (vecs[i]) begin
      if (!prev_keep) begin
        load = 1'b1;
        data = vecs[i].d;
      end
      run_frame(vecs[i].frame, vecs[i].pulse_at, vecs[i].keep, vecs[i].next_d);
      if (!vecs[i].keep) idle_check($sformatf("vec%0d", i));
      prev_keep = vecs[i].keep;
    end

    for (int r = 0; r < 6; r++) begin
      rd = 8'($urandom_range(0, 255));
      pa = $urandom_range(1, 38);
      load = 1'b1;
      data = rd;
      run_frame({1'b1, rd, 1'b0}, pa, 1'b0, 8'h00);
      idle_check($sformatf("rand%0d", r));
    end

    // reset inside data bit 3 of 8'hA5 (bit 3 is 0, so the line visibly jumps high)
    load = 1'b1;
    data = 8'hA5;
    for (int n = 0; n <= 17; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 0) load = 1'b0;
    end
    chk("pre-clr txd", txd, 1'b0);
    chk("pre-clr busy", busy, 1'b1);
    #2 clr = 1'b1;
    #1;
    chk("async clr txd", txd, 1'b1);
    chk("async clr ready", ready, 1'b1);
    chk("async clr busy", busy, 1'b0);
    chk("async clr done", done, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    for (int n = 0; n < 3; n++) idle_check("after clr");
    load = 1'b1;
    data = 8'h01;
    run_frame(10'h202, -5, 1'b0, 8'h00);
    idle_check("frame 01");

    // WIDTH=1, DIV=1: start, one data bit, stop, then idle with done
    for (int v = 0; v < 2; v++) begin
      load1 = 1'b1;
      data1 = 1'(v);
      exp_txd1 = {1'b1, 1'b1, 1'(v), 1'b0};
      for (int n = 0; n <= 3; n++) begin
        @(posedge clk);
        @(negedge clk);
        if (n == 0) load1 = 1'b0;
        chk($sformatf("div1 v=%0d txd n=%0d", v, n), txd1, exp_txd1[n]);
        chk($sformatf("div1 v=%0d done n=%0d", v, n), done1, n == 3);
        chk($sformatf("div1 v=%0d busy n=%0d", v, n), busy1, n < 3);
        chk($sformatf("div1 v=%0d ready n=%0d", v, n), ready1, n == 3);
      end
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("div1 v=%0d done clears", v), done1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
